// File: rtl/alu_pkg.sv
// Shared decode constants, FSM/op-class enums and small helpers for the
// alu_muldiv execute stage (multi-cycle unit enabled by ALU_MULDIV_EN).
package alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    typedef enum logic [2:0] {
        ARITH   = 3'd0,
        LOGIC   = 3'd1,
        SHIFT   = 3'd2,
        HILO    = 3'd3,
        MULDIV  = 3'd4,
        ILLEGAL = 3'd5
    } op_class_e;

    // Two's-complement overflow of r = a + b, judged from the sign bits only.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, followed by a one-cycle sign fixup.
`ifdef ALU_MULDIV_EN
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic                 is_div,
    input  logic [WORD_SIZE-1:0] op_a,
    input  logic [WORD_SIZE-1:0] op_b,
    output logic                 idle,
    output logic                 done,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int CW = $clog2(WORD_SIZE);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORD_SIZE - 1);

    md_state_e              state_r;
    md_state_e              state_s;
    logic [CW-1:0]          cnt_r;
    logic [WORD_SIZE-1:0]   acc_r;
    logic [WORD_SIZE-1:0]   low_r;
    logic [WORD_SIZE-1:0]   mcand_r;
    logic                   div_r;
    logic                   neg_q_r;
    logic                   neg_rem_r;
    logic                   dz_r;
    logic [WORD_SIZE-1:0]   acc_step_s;
    logic [WORD_SIZE-1:0]   low_step_s;
    logic [WORD_SIZE:0]     mul_sum_s;
    logic [WORD_SIZE:0]     div_shift_s;
    logic [2*WORD_SIZE-1:0] prod_s;
    logic [WORD_SIZE-1:0]   quo_s;
    logic [WORD_SIZE-1:0]   rem_s;

    function automatic logic [WORD_SIZE-1:0] magnitude(input logic [WORD_SIZE-1:0] v,
                                                       input logic sgn);
        return (sgn && v[WORD_SIZE-1]) ? -v : v;
    endfunction

    // Next-state logic for the IDLE -> ITER -> FIX sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = start ? ITER : IDLE;
            ITER:    state_s = (cnt_r == LAST_CNT) ? FIX : ITER;
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One radix-2 step: {acc,low} acts as product register or remainder/quotient pair.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (low_r[0] ? {1'b0, mcand_r} : {(WORD_SIZE+1){1'b0}});
        div_shift_s = {acc_r, low_r[WORD_SIZE-1]};
        acc_step_s  = acc_r;
        low_step_s  = low_r;
        if (div_r) begin
            if (div_shift_s >= {1'b0, mcand_r}) begin
                acc_step_s = div_shift_s[WORD_SIZE-1:0] - mcand_r;
                low_step_s = {low_r[WORD_SIZE-2:0], 1'b1};
            end else begin
                acc_step_s = div_shift_s[WORD_SIZE-1:0];
                low_step_s = {low_r[WORD_SIZE-2:0], 1'b0};
            end
        end else begin
            acc_step_s = mul_sum_s[WORD_SIZE:1];
            low_step_s = {mul_sum_s[0], low_r[WORD_SIZE-1:1]};
        end
    end

    // Sign fixup; a zero divisor still leaves the dividend as remainder.
    always_comb begin
        prod_s = {acc_r, low_r};
        quo_s  = low_r;
        rem_s  = acc_r;
        if (neg_q_r) begin
            prod_s = -prod_s;
            quo_s  = -low_r;
        end else begin
            prod_s = {acc_r, low_r};
            quo_s  = low_r;
        end
        if (neg_rem_r) begin
            rem_s = -acc_r;
        end else begin
            rem_s = acc_r;
        end
        if (dz_r) begin
            quo_s = {WORD_SIZE{1'b1}};
        end else begin
            quo_s = quo_s;
        end
    end

    assign idle = (state_r == IDLE);
    assign done = (state_r == FIX);
    assign hi   = div_r ? rem_s : prod_s[2*WORD_SIZE-1:WORD_SIZE];
    assign lo   = div_r ? quo_s : prod_s[WORD_SIZE-1:0];

    // Sequencer state, iteration counter and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {WORD_SIZE{1'b0}};
            low_r     <= {WORD_SIZE{1'b0}};
            mcand_r   <= {WORD_SIZE{1'b0}};
            div_r     <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cnt_r     <= {CW{1'b0}};
                        acc_r     <= {WORD_SIZE{1'b0}};
                        low_r     <= magnitude(op_a, is_signed);
                        mcand_r   <= magnitude(op_b, is_signed);
                        div_r     <= is_div;
                        neg_q_r   <= is_signed && (op_a[WORD_SIZE-1] ^ op_b[WORD_SIZE-1]);
                        neg_rem_r <= is_signed && op_a[WORD_SIZE-1];
                        dz_r      <= (op_b == {WORD_SIZE{1'b0}});
                    end
                end
                ITER: begin
                    acc_r <= acc_step_s;
                    low_r <= low_step_s;
                    cnt_r <= cnt_r + CW'(1'b1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule
`endif

// File: rtl/alu_muldiv.sv
// MIPS execute-stage ALU: single-cycle ops with one registered cycle of latency,
// plus an iterative MULT/DIV unit with HI/LO when ALU_MULDIV_EN is defined.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic [4:0]           shamt,
    input  logic [WORD_SIZE-1:0] src_a,
    input  logic [WORD_SIZE-1:0] src_b,
    input  logic [15:0]          imm,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] result,
    output logic                 ovf,
    output logic                 illegal,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int MSB    = WORD_SIZE - 1;
    localparam int LUI_SH = (WORD_SIZE >= 16) ? (WORD_SIZE - 16) : 0;

    op_class_e            cls_s;
    logic [WORD_SIZE-1:0] res_s;
    logic                 ovf_s;
    logic                 accept_s;
    logic [31:0]          sh_amt_s;
    logic [WORD_SIZE-1:0] sum_s;
    logic [WORD_SIZE-1:0] diff_s;
    logic [WORD_SIZE-1:0] imm_sext_s;
    logic [WORD_SIZE-1:0] imm_zext_s;
    logic [WORD_SIZE-1:0] addi_s;
    logic                 out_valid_r;
    logic [WORD_SIZE-1:0] result_r;
    logic                 ovf_r;
    logic                 illegal_r;

`ifdef ALU_MULDIV_EN
    logic [WORD_SIZE-1:0] hi_r;
    logic [WORD_SIZE-1:0] lo_r;
    logic [WORD_SIZE-1:0] md_hi_s;
    logic [WORD_SIZE-1:0] md_lo_s;
    logic                 md_start_s;
    logic                 md_idle_s;
    logic                 md_done_s;
    logic                 md_signed_s;
    logic                 md_div_s;
    logic                 hi_wr_s;
    logic                 lo_wr_s;
`endif

    assign accept_s   = in_valid && in_ready;
    assign sh_amt_s   = 32'(shamt) % 32'(WORD_SIZE);
    assign sum_s      = src_a + src_b;
    assign diff_s     = src_a - src_b;
    assign imm_sext_s = WORD_SIZE'($signed(imm));
    assign imm_zext_s = WORD_SIZE'(imm);
    assign addi_s     = src_a + imm_sext_s;

    // Decode and single-cycle datapath; illegal encodings leave result at zero.
    always_comb begin
        cls_s = ILLEGAL;
        res_s = {WORD_SIZE{1'b0}};
        ovf_s = 1'b0;
`ifdef ALU_MULDIV_EN
        md_signed_s = 1'b0;
        md_div_s    = 1'b0;
        hi_wr_s     = 1'b0;
        lo_wr_s     = 1'b0;
`endif
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:  begin cls_s = SHIFT; res_s = src_b << sh_amt_s; end
                    FN_SRL:  begin cls_s = SHIFT; res_s = src_b >> sh_amt_s; end
                    FN_SRA:  begin cls_s = SHIFT; res_s = WORD_SIZE'($signed(src_b) >>> sh_amt_s); end
`ifdef ALU_MULDIV_EN
                    FN_MFHI:  begin cls_s = HILO; res_s = hi_r; end
                    FN_MTHI:  begin cls_s = HILO; hi_wr_s = 1'b1; end
                    FN_MFLO:  begin cls_s = HILO; res_s = lo_r; end
                    FN_MTLO:  begin cls_s = HILO; lo_wr_s = 1'b1; end
                    FN_MULT:  begin cls_s = MULDIV; md_signed_s = 1'b1; end
                    FN_MULTU: begin cls_s = MULDIV; end
                    FN_DIV:   begin cls_s = MULDIV; md_signed_s = 1'b1; md_div_s = 1'b1; end
                    FN_DIVU:  begin cls_s = MULDIV; md_div_s = 1'b1; end
`endif
                    FN_ADD:  begin
                        cls_s = ARITH;
                        res_s = sum_s;
                        ovf_s = add_ovf(src_a[MSB], src_b[MSB], sum_s[MSB]);
                    end
                    FN_ADDU: begin cls_s = ARITH; res_s = sum_s; end
                    FN_SUB:  begin
                        cls_s = ARITH;
                        res_s = diff_s;
                        ovf_s = add_ovf(src_a[MSB], ~src_b[MSB], diff_s[MSB]);
                    end
                    FN_SUBU: begin cls_s = ARITH; res_s = diff_s; end
                    FN_AND:  begin cls_s = LOGIC; res_s = src_a & src_b; end
                    FN_OR:   begin cls_s = LOGIC; res_s = src_a | src_b; end
                    FN_XOR:  begin cls_s = LOGIC; res_s = src_a ^ src_b; end
                    FN_NOR:  begin cls_s = LOGIC; res_s = ~(src_a | src_b); end
                    FN_SLT:  begin cls_s = ARITH; res_s = WORD_SIZE'($signed(src_a) < $signed(src_b)); end
                    FN_SLTU: begin cls_s = ARITH; res_s = WORD_SIZE'(src_a < src_b); end
                    default: begin cls_s = ILLEGAL; res_s = {WORD_SIZE{1'b0}}; end
                endcase
            end
            OP_ADDI: begin
                cls_s = ARITH;
                res_s = addi_s;
                ovf_s = add_ovf(src_a[MSB], imm_sext_s[MSB], addi_s[MSB]);
            end
            OP_ADDIU: begin cls_s = ARITH; res_s = addi_s; end
            OP_SLTI:  begin cls_s = ARITH; res_s = WORD_SIZE'($signed(src_a) < $signed(imm_sext_s)); end
            OP_SLTIU: begin cls_s = ARITH; res_s = WORD_SIZE'(src_a < imm_sext_s); end
            OP_ANDI:  begin cls_s = LOGIC; res_s = src_a & imm_zext_s; end
            OP_ORI:   begin cls_s = LOGIC; res_s = src_a | imm_zext_s; end
            OP_XORI:  begin cls_s = LOGIC; res_s = src_a ^ imm_zext_s; end
            OP_LUI:   begin cls_s = LOGIC; res_s = imm_zext_s << LUI_SH; end
            default:  begin cls_s = ILLEGAL; res_s = {WORD_SIZE{1'b0}}; end
        endcase
    end

`ifdef ALU_MULDIV_EN
    assign md_start_s = accept_s && (cls_s == MULDIV);
    assign in_ready   = md_idle_s;
    assign hi         = hi_r;
    assign lo         = lo_r;

    muldiv_iter #(
        .WORD_SIZE (WORD_SIZE)
    ) u_muldiv_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start_s),
        .is_signed (md_signed_s),
        .is_div    (md_div_s),
        .op_a      (src_a),
        .op_b      (src_b),
        .idle      (md_idle_s),
        .done      (md_done_s),
        .hi        (md_hi_s),
        .lo        (md_lo_s)
    );

    // Architectural HI/LO: the multi-cycle result wins over MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= {WORD_SIZE{1'b0}};
            lo_r <= {WORD_SIZE{1'b0}};
        end else if (md_done_s) begin
            hi_r <= md_hi_s;
            lo_r <= md_lo_s;
        end else begin
            if (accept_s && hi_wr_s) begin
                hi_r <= src_a;
            end
            if (accept_s && lo_wr_s) begin
                lo_r <= src_a;
            end
        end
    end
`else
    assign in_ready = 1'b1;
    assign hi       = {WORD_SIZE{1'b0}};
    assign lo       = {WORD_SIZE{1'b0}};
`endif

    // Registered result pulse for single-cycle ops and multi-cycle completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= {WORD_SIZE{1'b0}};
            ovf_r       <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (accept_s && (cls_s != MULDIV)) begin
            out_valid_r <= 1'b1;
            result_r    <= res_s;
            ovf_r       <= ovf_s;
            illegal_r   <= (cls_s == ILLEGAL);
`ifdef ALU_MULDIV_EN
        end else if (md_done_s) begin
            out_valid_r <= 1'b1;
            result_r    <= {WORD_SIZE{1'b0}};
            ovf_r       <= 1'b0;
            illegal_r   <= 1'b0;
`endif
        end else begin
            out_valid_r <= 1'b0;
            result_r    <= {WORD_SIZE{1'b0}};
            ovf_r       <= 1'b0;
            illegal_r   <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign ovf       = ovf_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized self-checking bench for alu_muldiv against a plain-arithmetic
// reference model; adapts to builds with or without ALU_MULDIV_EN.
module tb_alu_muldiv;

    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [4:0]    shamt;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [15:0]   imm;
    logic          out_valid;
    logic [W-1:0]  result;
    logic          ovf;
    logic          illegal;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks   = 0;
    int failures = 0;

    // reference model state and last expectation
    logic [31:0] m_hi, m_lo;
    logic [31:0] exp_res;
    logic        exp_ovf, exp_ill;
    int          exp_lat;

    logic [5:0] r_tab [21] = '{6'h00, 6'h02, 6'h03, 6'h10, 6'h11, 6'h12, 6'h13,
                               6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22,
                               6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0] sc_tab [17] = '{6'h00, 6'h02, 6'h03, 6'h10, 6'h11, 6'h12, 6'h13,
                                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h2B};

    alu_muldiv #(.WORD_SIZE(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct     (funct),
        .shamt     (shamt),
        .src_a     (src_a),
        .src_b     (src_b),
        .imm       (imm),
        .out_valid (out_valid),
        .result    (result),
        .ovf       (ovf),
        .illegal   (illegal),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Architectural behaviour straight from the instruction definitions.
    task automatic model_exec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                              input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
        longint sa, sb, full;
        logic [63:0] p;
        logic [31:0] se, ze;
        int amt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        se = {{16{im[15]}}, im};
        ze = {16'h0000, im};
        amt = int'(sh) % 32;
        exp_res = 32'h0; exp_ovf = 1'b0; exp_ill = 1'b0; exp_lat = 1;
        if (op == 6'h00) begin
            case (fn)
                6'h00: exp_res = b << amt;
                6'h02: exp_res = b >> amt;
                6'h03: exp_res = 32'($signed(b) >>> amt);
                6'h10: if (MD_EN) exp_res = m_hi; else exp_ill = 1'b1;
                6'h11: if (MD_EN) m_hi = a; else exp_ill = 1'b1;
                6'h12: if (MD_EN) exp_res = m_lo; else exp_ill = 1'b1;
                6'h13: if (MD_EN) m_lo = a; else exp_ill = 1'b1;
                6'h18, 6'h19: begin
                    if (MD_EN) begin
                        if (fn == 6'h18) p = 64'(sa * sb);
                        else p = {32'h0, a} * {32'h0, b};
                        m_hi = p[63:32]; m_lo = p[31:0]; exp_lat = 34;
                    end else exp_ill = 1'b1;
                end
                6'h1A, 6'h1B: begin
                    if (MD_EN) begin
                        exp_lat = 34;
                        if (b == 32'h0) begin
                            m_lo = 32'hFFFF_FFFF; m_hi = a;
                        end else if (fn == 6'h1A) begin
                            m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
                        end else begin
                            m_lo = a / b; m_hi = a % b;
                        end
                    end else exp_ill = 1'b1;
                end
                6'h20, 6'h21, 6'h22, 6'h23: begin
                    full = (fn[1]) ? (sa - sb) : (sa + sb);
                    exp_res = 32'(full);
                    exp_ovf = !fn[0] && (full > 64'sd2147483647 || full < -64'sd2147483648);
                end
                6'h24: exp_res = a & b;
                6'h25: exp_res = a | b;
                6'h26: exp_res = a ^ b;
                6'h27: exp_res = ~(a | b);
                6'h2A: exp_res = (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: exp_res = (a < b) ? 32'd1 : 32'd0;
                default: exp_ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: begin
                    full = sa + longint'($signed(se));
                    exp_res = 32'(full);
                    exp_ovf = (op == 6'h08) && (full > 64'sd2147483647 || full < -64'sd2147483648);
                end
                6'h0A: exp_res = (sa < longint'($signed(se))) ? 32'd1 : 32'd0;
                6'h0B: exp_res = (a < se) ? 32'd1 : 32'd0;
                6'h0C: exp_res = a & ze;
                6'h0D: exp_res = a | ze;
                6'h0E: exp_res = a ^ ze;
                6'h0F: exp_res = {im, 16'h0000};
                default: exp_ill = 1'b1;
            endcase
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with a single-cycle valid, then scramble the inputs and wait for the pulse.
    task automatic do_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] im);
        int lat;
        opcode = op; funct = fn; shamt = sh; src_a = a; src_b = b; imm = im;
        in_valid = 1'b1;
        model_exec(op, fn, sh, a, b, im);
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode = 6'($urandom); funct = 6'($urandom); shamt = 5'($urandom);
        src_a = $urandom; src_b = $urandom; imm = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, ".res"}, 64'(result), 64'(exp_res));
        check_val({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
        check_val({tag, ".ill"}, 64'(illegal), 64'(exp_ill));
        check_val({tag, ".hi"}, 64'(hi), 64'(MD_EN ? m_hi : 32'h0));
        check_val({tag, ".lo"}, 64'(lo), 64'(MD_EN ? m_lo : 32'h0));
    endtask

    initial begin
        int stall, pulses;
        logic [31:0] q_res [16];
        logic        q_ill [16];
        logic [5:0]  op, fn;

        m_hi = 32'h0; m_lo = 32'h0;
        rst = 1'b1; in_valid = 1'b0;
        opcode = 6'h0; funct = 6'h0; shamt = 5'h0; src_a = 32'h0; src_b = 32'h0; imm = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_val("reset.out_valid", 64'(out_valid), 64'(0));
        check_val("reset.result", 64'(result), 64'(0));
        check_val("reset.flags", 64'({ovf, illegal}), 64'(0));
        check_val("reset.hilo", 64'({hi, lo}), 64'(0));
        check_val("reset.in_ready", 64'(in_ready), 64'(1));

        // directed cases
        do_op("add_ovf", 6'h00, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1, 16'h0);
        check_val("add_ovf.const", 64'({ovf, result}), {31'h0, 1'b1, 32'h8000_0000});
        do_op("addu", 6'h00, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'h1, 16'h0);
        do_op("sub_ovf", 6'h00, 6'h22, 5'd0, 32'h8000_0000, 32'h1, 16'h0);
        do_op("mult", 6'h00, 6'h18, 5'd0, -32'd3, 32'd7, 16'h0);
        do_op("multu", 6'h00, 6'h19, 5'd0, 32'hFFFF_FFFF, 32'd2, 16'h0);
        do_op("div", 6'h00, 6'h1A, 5'd0, -32'd7, 32'd2, 16'h0);
        do_op("divu0", 6'h00, 6'h1B, 5'd0, 32'd5, 32'd0, 16'h0);
        do_op("divmin", 6'h00, 6'h1A, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0);
        do_op("sra", 6'h00, 6'h03, 5'd31, 32'h0, 32'h8000_0000, 16'h0);
        do_op("lui", 6'h0F, 6'h00, 5'd0, 32'h1234, 32'h0, 16'hBEEF);
        do_op("ill_fn", 6'h00, 6'h3F, 5'd0, 32'hFFFF, 32'h1, 16'h0);
        do_op("ill_op", 6'h3E, 6'h20, 5'd0, 32'hFFFF, 32'h1, 16'h0);

        // MULT followed by a held MFLO: stalled until the product lands
        opcode = 6'h00; funct = 6'h18; src_a = -32'd3; src_b = 32'd9; in_valid = 1'b1;
        model_exec(6'h00, 6'h18, 5'd0, -32'd3, 32'd9, 16'h0);
        @(posedge clk); #1;
        funct = 6'h12; src_a = $urandom; src_b = $urandom;
        stall = 0;
        while (!in_ready && stall < 100) begin
            @(posedge clk); #1;
            stall++;
        end
        check_val("stall.cycles", 64'(stall), 64'(MD_EN ? 33 : 0));
        check_val("stall.mult_valid", 64'(out_valid), 64'(1));
        check_val("stall.lo", 64'(lo), 64'(MD_EN ? m_lo : 32'h0));
        model_exec(6'h00, 6'h12, 5'd0, src_a, src_b, 16'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("mflo.valid", 64'(out_valid), 64'(1));
        check_val("mflo.res", 64'(result), 64'(exp_res));
        check_val("mflo.ill", 64'(illegal), 64'(exp_ill));

        // reset in the middle of a DIV
        opcode = 6'h00; funct = 6'h1A; src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
        end
        check_val("rst.pre_pulses", 64'(pulses), 64'(MD_EN ? 0 : 1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        check_val("rst.in_ready", 64'(in_ready), 64'(1));
        check_val("rst.hilo", 64'({hi, lo}), 64'(0));
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
        end
        check_val("rst.post_pulses", 64'(pulses), 64'(0));
        do_op("addi", 6'h08, 6'h00, 5'd0, 32'd5, 32'h0, 16'hFFFF);
        check_val("addi.const", 64'(result), 64'(4));

        // back-to-back single-cycle ops, one accepted per cycle
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                op = 6'h00; fn = sc_tab[$urandom_range(0, 16)];
            end else begin
                op = 6'(6'h08 + 6'($urandom_range(0, 7))); fn = 6'($urandom);
            end
            opcode = op; funct = fn; shamt = 5'($urandom);
            src_a = rand_word(); src_b = rand_word(); imm = 16'($urandom);
            in_valid = 1'b1;
            model_exec(op, fn, shamt, src_a, src_b, imm);
            q_res[i] = exp_res; q_ill[i] = exp_ill;
            @(posedge clk); #1;
            check_val("b2b.valid", 64'(out_valid), 64'(1));
            check_val("b2b.res", 64'(result), 64'(q_res[i]));
            check_val("b2b.ill", 64'(illegal), 64'(q_ill[i]));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // randomized mix including multi-cycle and illegal encodings
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin op = 6'h00; fn = r_tab[$urandom_range(0, 20)]; end
                5, 6, 7, 8:    begin op = 6'(6'h08 + 6'($urandom_range(0, 7))); fn = 6'($urandom); end
                default:       begin op = 6'($urandom); fn = 6'($urandom); end
            endcase
            do_op("rand", op, fn, 5'($urandom), rand_word(), rand_word(), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised MIPS execute-stage ALU. Decodes R-type funct and I-type opcode, computes single-cycle integer ops with one registered cycle of latency, and runs MULT/MULTU/DIV/DIVU iteratively into architectural HI/LO registers. Sits between register-read and writeback. A valid/ready handshake stalls issue while a multi-cycle op is in flight.

## Interface
- WORD_SIZE, 32, datapath width; even, ≥ 8.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept; `in_valid & in_ready` = accept.
- opcode  in  6  instruction opcode.
- funct  in  6  R-type funct; used only when opcode = 0.
- shamt  in  5  shift amount for SLL/SRL/SRA.
- src_a  in  WORD_SIZE  rs value.
- src_b  in  WORD_SIZE  rt value; ignored for I-type.
- imm  in  16  I-type immediate.
- out_valid  out  1  one-cycle result pulse.
- result  out  WORD_SIZE  rd/rt write value; 0 when not applicable.
- ovf  out  1  signed overflow on ADD/SUB/ADDI; qualified by out_valid.
- illegal  out  1  undecoded opcode/funct; qualified by out_valid.
- hi, lo  out  WORD_SIZE each  architectural HI/LO.

## Operation
- R-type funct: 00 SLL, 02 SRL, 03 SRA, 10 MFHI, 11 MTHI, 12 MFLO, 13 MTLO, 18 MULT, 19 MULTU, 1A DIV, 1B DIVU, 20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU.
- I-type opcodes: 08 ADDI, 09 ADDIU, 0A SLTI, 0B SLTIU (imm sign-extended; SLTIU compares unsigned), 0C ANDI, 0D ORI, 0E XORI (imm zero-extended), 0F LUI (imm in the upper 16 bits; WORD_SIZE ≥ 16 required).
- ADD/SUB/ADDI: ovf=1 on signed overflow; result is still the wrapped sum. ADDU/SUBU/ADDIU never set ovf.
- Shifts: amount = shamt mod WORD_SIZE.
- MTHI/MTLO: HI/LO takes src_a on the accept edge; result=0.
- MULT/MULTU: 2·WORD_SIZE product; HI = upper half, LO = lower half.
- DIV/DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: LO = all-ones, HI = dividend. Signed MIN/−1: LO = MIN, HI = 0.
- Multi-cycle ops: result=0, ovf=0.
- Illegal: illegal=1, result=0, HI/LO unchanged.
- FSM: IDLE → (accept MULT*/DIV*) → ITER, WORD_SIZE cycles, radix-2 shift-add / restoring divide on magnitudes → FIX, 1 cycle: sign correction, HI/LO written → IDLE.
- in_ready = (state == IDLE).

## Timing
- Reset values: out_valid=0, result=0, ovf=0, illegal=0, hi=0, lo=0, in_ready=1, state IDLE.
- Single-cycle ops and MF/MT: out_valid in the cycle after accept. Throughput one op per cycle, back-to-back.
- MULT*/DIV*: out_valid exactly WORD_SIZE+2 cycles after the accept edge (34 for WORD_SIZE=32). HI/LO become visible in that same cycle. in_ready returns high in that same cycle, so a new op can be accepted alongside the pulse.
- MFHI/MFLO issued right after a MULT: stalled by in_ready; returns the new value.
- Operands are captured at accept; later input changes have no effect.
- rst mid-ITER/FIX: op aborted, no out_valid, HI/LO cleared, IDLE on the next cycle.
- in_valid while in_ready=0: ignored. Upstream holds it.

## Configuration
- ALU_MULDIV_EN defined: multi-cycle unit, HI/LO, and MF/MT ops present as above.
- ALU_MULDIV_EN undefined: funct 10–13 and 18–1B decode as illegal; hi/lo tied 0; in_ready constant 1; ITER/FIX logic is removed.

## Structure
- Package alu_pkg holds the opcode and funct localparams, the FSM state enum (IDLE, ITER, FIX), and the op-class enum (ARITH, LOGIC, SHIFT, HILO, MULDIV, ILLEGAL).
- Sub-module muldiv_iter holds the iteration counter, the shift-add/restoring-divide datapath, and the sign fixup. It exposes start/signed/is_div/done/hi/lo. The top module owns decode, the single-cycle datapath, the handshake, and the HI/LO registers.

## Test plan
- ADD 0x7FFFFFFF+1 → result 0x80000000, ovf=1. ADDU same operands → ovf=0. Both return out_valid one cycle after accept.
- MULT −3×7 → out_valid at cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5/0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- MULT accepted, in_valid held with MFLO → in_ready low for 33 cycles; MFLO accepted in the out_valid cycle; returns the new LO one cycle later.
- rst pulsed at iteration 10 of a DIV → no out_valid; hi=lo=0; in_ready=1 the next cycle; a following ADDI 5+(−1) returns 4.
- Funct 0x3F → illegal=1, result 0. Without ALU_MULDIV_EN, MULT → illegal=1 with 1-cycle latency.
